c2s_stream_arbiter: RTL

Packet-granular scheduler that shares one C2S AXI-Stream channel of the PCIe wrapper between `NUM_PORTS` traffic sources, for example several `full_dup_tester`-style generators. Grants are round-robin with a per-grant packet quantum and a host-controlled per-port enable. The block never interleaves beats of different packets. A single registered output stage drives the PCIe core's C2S slave, and each output beat is tagged with its source port.

---
 rtl/c2s_stream_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/c2s_stream_arbiter.sv
// Round-robin packet scheduler sharing one C2S AXI-Stream channel
// between NUM_PORTS sources, with per-grant packet quantum.
module c2s_stream_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int DATA_WIDTH    = 128,
  parameter int KEEP_WIDTH    = DATA_WIDTH/32,
  parameter int USER_WIDTH    = 33,
  parameter int QUANTUM_WIDTH = 8,
  parameter int ID_WIDTH      = $clog2(NUM_PORTS)
) (
  input  logic                             s_axi_clk,
  input  logic                             s_axi_rst,
  input  logic [NUM_PORTS-1:0]             port_enable,
  input  logic [QUANTUM_WIDTH-1:0]         quantum,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_axis_tuser,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [NUM_PORTS-1:0]             grant,
  output logic                             pkt_done,
  output logic [ID_WIDTH-1:0]              pkt_done_port
);

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam logic [ID_WIDTH:0]   NP      = (ID_WIDTH+1)'(NUM_PORTS);
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_PORTS-1);

  state_t                   state_q, state_d;
  logic [NUM_PORTS-1:0]     grant_q, grant_d;
  logic [ID_WIDTH-1:0]      gnt_id_q, gnt_id_d;
  logic [ID_WIDTH-1:0]      start_ptr_q, start_ptr_d;
  logic [QUANTUM_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [DATA_WIDTH-1:0]    tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0]    tkeep_q, tkeep_d;
  logic                     tlast_q, tlast_d;
  logic [USER_WIDTH-1:0]    tuser_q, tuser_d;
  logic [ID_WIDTH-1:0]      tid_q, tid_d;
  logic                     tvalid_q, tvalid_d;
  logic                     pkt_done_q, pkt_done_d;
  logic [ID_WIDTH-1:0]      done_port_q, done_port_d;

  logic [NUM_PORTS-1:0]     elig;
  logic                     found;
  logic [ID_WIDTH-1:0]      sel_id;
  logic [ID_WIDTH:0]        idx;
  logic                     out_free;
  logic                     in_fire;
  logic                     in_last;
  logic [QUANTUM_WIDTH:0]   cnt_inc;
  logic [QUANTUM_WIDTH:0]   q_eff;
  logic                     exhausted;

  assign elig     = s_axis_tvalid & port_enable;
  assign out_free = !tvalid_q || m_axis_tready;
  assign in_last  = s_axis_tlast[gnt_id_q];
  assign in_fire  = (state_q == XFER)
                 && s_axis_tvalid[gnt_id_q]
                 && out_free;

  assign cnt_inc   = {1'b0, pkt_cnt_q} + (QUANTUM_WIDTH+1)'(1);
  assign q_eff     = (quantum == '0) ? (QUANTUM_WIDTH+1)'(1)
                                     : {1'b0, quantum};
  assign exhausted = (cnt_inc >= q_eff);

  // First eligible port at or after start_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    sel_id = '0;
    idx    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = {1'b0, start_ptr_q} + (ID_WIDTH+1)'(i);
      if (idx >= NP) idx = idx - NP;
      if (!found && elig[idx[ID_WIDTH-1:0]]) begin
        found  = 1'b1;
        sel_id = idx[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    if (state_q == XFER) s_axis_tready[gnt_id_q] = out_free;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gnt_id_d    = gnt_id_q;
    start_ptr_d = start_ptr_q;
    pkt_cnt_d   = pkt_cnt_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    tuser_d     = tuser_q;
    tid_d       = tid_q;
    tvalid_d    = tvalid_q;
    pkt_done_d  = tvalid_q && m_axis_tready && tlast_q;
    done_port_d = done_port_q;
    if (pkt_done_d) done_port_d = tid_q;

    unique case (state_q)
      ARB: begin
        if (found) begin
          state_d  = XFER;
          gnt_id_d = sel_id;
          grant_d  = NUM_PORTS'(1) << sel_id;
          if (sel_id != gnt_id_q) pkt_cnt_d = '0;
        end
      end
      XFER: begin
        if (in_fire && in_last) begin
          state_d = ARB;
          grant_d = '0;
          if (exhausted) begin
            pkt_cnt_d   = '0;
            start_ptr_d = (gnt_id_q == LAST_ID) ? '0
                        : gnt_id_q + ID_WIDTH'(1);
          end else begin
            pkt_cnt_d   = cnt_inc[QUANTUM_WIDTH-1:0];
            start_ptr_d = gnt_id_q;
          end
        end
      end
      default: state_d = ARB;
    endcase

    if (in_fire) begin
      tdata_d  = s_axis_tdata[gnt_id_q*DATA_WIDTH +: DATA_WIDTH];
      tkeep_d  = s_axis_tkeep[gnt_id_q*KEEP_WIDTH +: KEEP_WIDTH];
      tuser_d  = s_axis_tuser[gnt_id_q*USER_WIDTH +: USER_WIDTH];
      tlast_d  = in_last;
      tid_d    = gnt_id_q;
      tvalid_d = 1'b1;
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge s_axi_clk) begin
    if (s_axi_rst) begin
      state_q     <= ARB;
      grant_q     <= '0;
      gnt_id_q    <= '0;
      start_ptr_q <= '0;
      pkt_cnt_q   <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      tuser_q     <= '0;
      tid_q       <= '0;
      tvalid_q    <= 1'b0;
      pkt_done_q  <= 1'b0;
      done_port_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gnt_id_q    <= gnt_id_d;
      start_ptr_q <= start_ptr_d;
      pkt_cnt_q   <= pkt_cnt_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      tid_q       <= tid_d;
      tvalid_q    <= tvalid_d;
      pkt_done_q  <= pkt_done_d;
      done_port_q <= done_port_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tid    = tid_q;
  assign m_axis_tvalid = tvalid_q;
  assign grant         = grant_q;
  assign pkt_done      = pkt_done_q;
  assign pkt_done_port = done_port_q;

endmodule
